cd_host_initiator: RTL
======================

CD_HOST_INITIATOR -- requirements
Module: cd_host_initiator

Interface
REQ-001 Parameter DATA_W, default 80: width of the uncompressed data word.
REQ-002 Parameter CODE_W, default 8: width of the compressed code word.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of WAIT cycles for a codec response; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_op  input  2  requested operation: 01 = COMPRESS, 10 = DECOMPRESS, 00/11 = illegal.
REQ-009 req_data  input  DATA_W  word to compress.
REQ-010 req_code  input  CODE_W  code to decompress.
REQ-011 command  output  2  codec command: 00 = NOP, 01 = COMPRESS, 10 = DECOMPRESS.
REQ-012 data_in  output  DATA_W  codec data operand.
REQ-013 compressed_in  output  CODE_W  codec code operand.
REQ-014 compressed_out  input  CODE_W  codec compression result.
REQ-015 decompressed_out  input  DATA_W  codec decompression result.
REQ-016 response  input  2  codec status: 00 = none, 01 = OK, 10 = FAIL, 11 = reserved (treated as FAIL).
REQ-017 rsp_valid  output  1  result available to the host.
REQ-018 rsp_ready  input  1  host accepts the result.
REQ-019 rsp_status  output  2  00 = OK, 01 = codec FAIL, 10 = TIMEOUT, 11 = ILLEGAL_OP.
REQ-020 rsp_code  output  CODE_W  captured compressed_out (COMPRESS only; 0 otherwise).
REQ-021 rsp_data  output  DATA_W  captured decompressed_out (DECOMPRESS only; 0 otherwise).
REQ-022 err_count  output  16  saturating count of non-OK results delivered to the host.

Function
REQ-023 The FSM SHALL have four states (IDLE, ISSUE, WAIT, RESP) and SHALL reset to IDLE.
REQ-024 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-025 On accepting a legal op: latch op, req_data and req_code; go to ISSUE.
REQ-026 On accepting an illegal op (00 or 11): go directly to RESP with rsp_status = 11; never drive a codec command.
REQ-027 In ISSUE, command SHALL equal the latched op for exactly one cycle, then the FSM goes to WAIT.
REQ-028 command SHALL be 00 in every state other than ISSUE.
REQ-029 data_in and compressed_in SHALL hold the latched operands from ISSUE until the FSM leaves WAIT; they SHALL be 0 after reset.
REQ-030 WAIT: on the first cycle with response != 00, capture the result and go to RESP; 01 gives status 00, 10 or 11 gives status 01.
REQ-031 A WAIT-cycle counter SHALL be cleared on entry to WAIT; if TIMEOUT_CYCLES WAIT cycles pass with response = 00, go to RESP with status 10 and rsp_code/rsp_data = 0.
REQ-032 A response arriving on the same cycle the timeout expires SHALL win over the timeout.
REQ-033 Any response seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-034 rsp_valid SHALL be 1 only in RESP; rsp_* SHALL stay stable while rsp_valid = 1 and rsp_ready = 0.
REQ-035 When rsp_valid and rsp_ready are both 1: return to IDLE; if status != 00, increment err_count, saturating at 0xFFFF.
REQ-036 Minimum latency SHALL be 3 cycles from acceptance to rsp_valid: ISSUE, one WAIT cycle, then RESP.
REQ-037 Only one transaction SHALL be outstanding; there are no back-to-back requests without a pass through IDLE.

Reset
REQ-038 Asserting reset SHALL immediately force: FSM = IDLE, req_ready = 1, command = 00, data_in = 0, compressed_in = 0, rsp_valid = 0, rsp_status = 00, rsp_code = 0, rsp_data = 0, err_count = 0, timeout counter = 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction with no host response; responses arriving after reset are ignored per REQ-033.

Verification
REQ-040 COMPRESS, data all ones; codec returns response 01 with compressed_out 0xF0 two cycles after ISSUE -> rsp_valid with status 00, rsp_code 0xF0, rsp_data 0, err_count 0.
REQ-041 DECOMPRESS, code 0x05; codec returns 10 -> status 01, rsp_data 0; err_count = 1 after handshake.
REQ-042 Codec never responds, TIMEOUT_CYCLES = 4 -> rsp_valid on the 5th cycle after ISSUE, status 10, command 00 throughout WAIT.
REQ-043 req_op = 11 -> command stays 00, rsp_valid on the cycle after acceptance, status 11.
REQ-044 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready = 0, a new req_valid is not accepted.
REQ-045 Reset asserted during WAIT, codec response 01 one cycle after release -> no rsp_valid, FSM in IDLE, all outputs at reset values.

Source files
------------

// File: rtl/cd_host_initiator.sv
// cd_host_initiator: host-side sequencer that issues one compress/decompress command to a codec,
// waits for its status with a timeout, and returns a registered result to the host.
module cd_host_initiator #(
    parameter int DATA_W         = 80,
    parameter int CODE_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [CODE_W-1:0] req_code,
    output logic [1:0]        command,
    output logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] compressed_in,
    input  logic [CODE_W-1:0] compressed_out,
    input  logic [DATA_W-1:0] decompressed_out,
    input  logic [1:0]        response,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [CODE_W-1:0] rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic [15:0]       err_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state;
    logic [1:0] op;
    logic [7:0] wait_cnt;
    logic       legal, got_rsp, rsp_ok, timeout;
    assign legal   = req_op == 2'b01 || req_op == 2'b10;
    assign got_rsp = response != 2'b00;
    assign rsp_ok  = response == 2'b01;
    assign timeout = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
    // A codec response is checked before the timeout so a late-but-in-time answer wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op            <= 2'b00;
            wait_cnt      <= 8'd0;
            req_ready     <= 1'b1;
            command       <= 2'b00;
            data_in       <= '0;
            compressed_in <= '0;
            rsp_valid     <= 1'b0;
            rsp_status    <= 2'b00;
            rsp_code      <= '0;
            rsp_data      <= '0;
            err_count     <= 16'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    rsp_code  <= '0;
                    rsp_data  <= '0;
                    if (legal) begin
                        state         <= ISSUE;
                        op            <= req_op;
                        command       <= req_op;
                        data_in       <= req_data;
                        compressed_in <= req_code;
                    end else begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'b11;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    command  <= 2'b00;
                    wait_cnt <= 8'd0;
                end
                WAIT: if (got_rsp || timeout) begin
                    state         <= RESP;
                    rsp_valid     <= 1'b1;
                    data_in       <= '0;
                    compressed_in <= '0;
                    rsp_status    <= got_rsp ? (rsp_ok ? 2'b00 : 2'b01) : 2'b10;
                    rsp_code      <= (got_rsp && rsp_ok && op == 2'b01) ? compressed_out : '0;
                    rsp_data      <= (got_rsp && rsp_ok && op == 2'b10) ? decompressed_out : '0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    if (rsp_status != 2'b00 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
